// File: rtl/z80_bus_responder.sv
// Memory/IO responder on the pin side of a Z80: decodes registered CPU strobes, serves RAM, one IO port,
// the interrupt vector and refresh cycles, and drives nINT. Optional write-protected low region: Z80_RESP_ROM_EN.
module z80_bus_responder #(
    parameter int          ADDR_BITS  = 10,
    parameter logic [7:0]  IO_PORT    = 8'h10,
    parameter logic [7:0]  INT_VECTOR = 8'hFF
`ifdef Z80_RESP_ROM_EN
    ,
    parameter logic [15:0] ROM_TOP    = 16'h0100
`endif
) (
    input  logic        CPUCLK,
    input  logic        RESET,
    input  logic        nM1,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nRFSH,
    input  logic [15:0] A,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic        irq_req,
    output logic        nINT,
    input  logic [7:0]  io_in,
    output logic [7:0]  io_out,
`ifdef Z80_RESP_ROM_EN
    output logic        rom_wr_err,
`endif
    output logic [2:0]  bus_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MRD  = 3'd1,
        S_MWR  = 3'd2,
        S_IORD = 3'd3,
        S_IOWR = 3'd4,
        S_INTA = 3'd5,
        S_RFSH = 3'd6,
        S_SYNC = 3'd7
    } state_t;

    logic                 nm1_q, nmreq_q, niorq_q, nrd_q, nwr_q, nrfsh_q;
    logic [15:0]          a_q;
    logic [7:0]           din_q;

    state_t               state_q, state_d;
    logic [7:0]           d_out_q, d_out_d;
    logic                 d_oe_q, d_oe_d;
    logic [7:0]           io_out_q, io_out_d;
    logic                 pending_q, pending_d;
    logic                 inta_entry;
    logic                 ram_we;
`ifdef Z80_RESP_ROM_EN
    logic                 rom_err_q, rom_err_d;
`endif

    logic [7:0]           ram [2**ADDR_BITS];
    logic [ADDR_BITS-1:0] ram_idx;

    assign ram_idx = a_q[ADDR_BITS-1:0];

    // Upper address bits are ignored by the RAM decode (mirroring).
    logic unused_a_hi;
    assign unused_a_hi = ^a_q[15:ADDR_BITS];

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge CPUCLK) begin
        nm1_q   <= nM1;
        nmreq_q <= nMREQ;
        niorq_q <= nIORQ;
        nrd_q   <= nRD;
        nwr_q   <= nWR;
        nrfsh_q <= nRFSH;
        a_q     <= A;
        din_q   <= D_in;
    end

    always_ff @(posedge CPUCLK) begin
        if (RESET) begin
            state_q   <= S_SYNC;
            d_out_q   <= 8'h00;
            d_oe_q    <= 1'b0;
            io_out_q  <= 8'h00;
            pending_q <= 1'b0;
`ifdef Z80_RESP_ROM_EN
            rom_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            d_out_q   <= d_out_d;
            d_oe_q    <= d_oe_d;
            io_out_q  <= io_out_d;
            pending_q <= pending_d;
`ifdef Z80_RESP_ROM_EN
            rom_err_q <= rom_err_d;
`endif
        end
    end

    // NOTE: the RAM has no reset; contents survive RESET, only the write strobe is gated.
    always_ff @(posedge CPUCLK) begin
        if (!RESET && ram_we) begin
            ram[ram_idx] <= din_q;
        end
    end

    // NOTE: every signal gets a default first so this block can never infer a latch.
    always_comb begin
        state_d    = state_q;
        d_out_d    = d_out_q;
        d_oe_d     = d_oe_q;
        io_out_d   = io_out_q;
        inta_entry = 1'b0;
        ram_we     = 1'b0;
`ifdef Z80_RESP_ROM_EN
        rom_err_d  = 1'b0;
`endif
        case (state_q)
            S_SYNC: if (nmreq_q && niorq_q) state_d = S_IDLE;
            S_IDLE: begin
                if (!nm1_q && !niorq_q) begin
                    state_d    = S_INTA;
                    d_out_d    = INT_VECTOR;
                    d_oe_d     = 1'b1;
                    inta_entry = 1'b1;
                end else if (!nmreq_q && !nrfsh_q) begin
                    state_d = S_RFSH;
                end else if (!nmreq_q && !nrd_q) begin
                    state_d = S_MRD;
                    d_out_d = ram[ram_idx];
                    d_oe_d  = 1'b1;
                end else if (!nmreq_q && !nwr_q) begin
                    state_d = S_MWR;
`ifdef Z80_RESP_ROM_EN
                    if (a_q < ROM_TOP) rom_err_d = 1'b1;
                    else               ram_we    = 1'b1;
`else
                    ram_we  = 1'b1;
`endif
                end else if (!niorq_q && !nrd_q) begin
                    state_d = S_IORD;
                    if (a_q[7:0] == IO_PORT) begin
                        d_out_d = io_in;
                        d_oe_d  = 1'b1;
                    end
                end else if (!niorq_q && !nwr_q) begin
                    state_d = S_IOWR;
                    if (a_q[7:0] == IO_PORT) io_out_d = din_q;
                end
            end
            S_MRD: if (nmreq_q || nrd_q) begin
                state_d = S_IDLE;
                d_oe_d  = 1'b0;
            end
            S_MWR:  if (nmreq_q || nwr_q) state_d = S_IDLE;
            S_IORD: if (niorq_q || nrd_q) begin
                state_d = S_IDLE;
                d_oe_d  = 1'b0;
            end
            S_IOWR: if (niorq_q || nwr_q) state_d = S_IDLE;
            S_INTA: if (niorq_q) begin
                state_d = S_IDLE;
                d_oe_d  = 1'b0;
            end
            S_RFSH: if (nmreq_q) state_d = S_IDLE;
            default: state_d = S_SYNC;
        endcase
        // A new request in the acknowledge cycle wins over the clear.
        pending_d = irq_req | (pending_q & ~inta_entry);
    end

    assign D_out     = d_out_q;
    assign D_oe      = d_oe_q;
    assign io_out    = io_out_q;
    assign nINT      = ~pending_q;
    assign bus_state = state_q;
`ifdef Z80_RESP_ROM_EN
    assign rom_wr_err = rom_err_q;
`endif

endmodule
